multicycle_controller: RTL and testbench

// Multi-cycle sequencer for the 4-bit-opcode datapath.
// - Drives fetch, decode, execute, memory and writeback phases.
// - Gates the per-opcode control word so register, flag and memory writes fire only in their phase.
// - Handshakes with the iterative mul/div unit and the data memory.
// - Sits between the instruction register/opcode decoder and the PC, register file, ALU and memory enables.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/md_timeout_counter.sv | 28 ++
 rtl/multicycle_controller.sv | 144 ++++++++++++++
 tb/tb_multicycle_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and opcode map for the multi-cycle sequencer.
// The op-class helper groups opcodes by the phase sequence they follow.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMdWait,
    StMem,
    StWb
  } state_t;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsMd,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsBeq,
    ClsNop
  } op_class_t;

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_MULI = 4'b0001;
  localparam logic [3:0] OP_DIVI = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_LDR  = 4'b0101;
  localparam logic [3:0] OP_STR  = 4'b0110;
  localparam logic [3:0] OP_B    = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1111;

  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_ADDI:         cls = ClsAlu;
      OP_MUL, OP_MULI, OP_DIVI: cls = ClsMd;
      OP_LDR:                  cls = ClsLoad;
      OP_STR:                  cls = ClsStore;
      OP_B:                    cls = ClsBranch;
      OP_BEQ:                  cls = ClsBeq;
      default:                 cls = ClsNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// 8-bit wait counter for the mul/div handshake; expired marks the last allowed wait cycle.
module md_timeout_counter #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] Last = 8'(Timeout - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == Last);

endmodule

// File: rtl/multicycle_controller.sv
// Fetch/decode/execute/memory/writeback sequencer that gates the per-opcode
// control strobes into their phase and handshakes with mul/div and data memory.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       imemAck,
  input  logic       memReady,
  input  logic       mdDone,
  input  logic       zeroFlag,
  output logic       imemReq,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSel,
  output logic       regWriteEn,
  output logic       flagWriteEn,
  output logic       memReadEn,
  output logic       memWriteEn,
  output logic       mdStart,
  output logic       mdFault
);

  state_t    state_q, state_d;
  logic      md_fault_q, md_fault_d;
  logic      md_expired;
  op_class_t cls;

  assign cls     = op_class(opcode);
  assign mdFault = md_fault_q;

  md_timeout_counter #(
    .Timeout(MD_TIMEOUT)
  ) u_md_timeout_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == StExec && cls == ClsMd),
    .enable (state_q == StMdWait && !mdDone),
    .expired(md_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      md_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_fault_q <= md_fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_fault_d  = md_fault_q;
    imemReq     = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSel       = 1'b0;
    regWriteEn  = 1'b0;
    flagWriteEn = 1'b0;
    memReadEn   = 1'b0;
    memWriteEn  = 1'b0;
    mdStart     = 1'b0;

    unique case (state_q)
      StFetch: begin
        imemReq = 1'b1;
        if (imemAck) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        case (cls)
          ClsAlu: begin
            flagWriteEn = 1'b1;
            state_d     = StWb;
          end
          ClsMd: begin
            mdStart = 1'b1;
            state_d = StMdWait;
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch: begin
            pcWrite = 1'b1;
            pcSel   = 1'b1;
            state_d = StFetch;
          end
          ClsBeq: begin
            pcWrite = zeroFlag;
            pcSel   = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMdWait: begin
        // A result arriving on the expiry cycle still takes priority over the abort.
        if (mdDone) begin
          flagWriteEn = 1'b1;
          state_d     = StWb;
        end else if (md_expired) begin
          md_fault_d = 1'b1;
          state_d    = StFetch;
        end
      end
      StMem: begin
        if (cls == ClsLoad) begin
          memReadEn = 1'b1;
          if (memReady) state_d = StWb;
        end else if (cls == ClsStore) begin
          memWriteEn = 1'b1;
          if (memReady) state_d = StFetch;
        end else begin
          state_d = StFetch;
        end
      end
      StWb: begin
        regWriteEn = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Strobes must drop as soon as reset rises, not at the next edge.
    if (rst) begin
      imemReq     = 1'b0;
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      pcSel       = 1'b0;
      regWriteEn  = 1'b0;
      flagWriteEn = 1'b0;
      memReadEn   = 1'b0;
      memWriteEn  = 1'b0;
      mdStart     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scripted bench: each driven cycle pushes its expected output vector, a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam logic [9:0] E_NONE = 10'b0000000000;
  localparam logic [9:0] E_IMEM = 10'b1000000000;
  localparam logic [9:0] E_IR   = 10'b0100000000;
  localparam logic [9:0] E_PCW  = 10'b0010000000;
  localparam logic [9:0] E_PCS  = 10'b0001000000;
  localparam logic [9:0] E_RW   = 10'b0000100000;
  localparam logic [9:0] E_FW   = 10'b0000010000;
  localparam logic [9:0] E_MR   = 10'b0000001000;
  localparam logic [9:0] E_MW   = 10'b0000000100;
  localparam logic [9:0] E_MDS  = 10'b0000000010;
  localparam logic [9:0] E_FLT  = 10'b0000000001;

  typedef struct {
    string      tag;
    bit         sel;
    logic [9:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       imemAck = 1'b0;
  logic       memReady = 1'b0;
  logic       mdDone = 1'b0;
  logic       zeroFlag = 1'b0;
  logic [9:0] out_a, out_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  multicycle_controller dut_a (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .imemAck    (imemAck),
    .memReady   (memReady),
    .mdDone     (mdDone),
    .zeroFlag   (zeroFlag),
    .imemReq    (out_a[9]),
    .irWrite    (out_a[8]),
    .pcWrite    (out_a[7]),
    .pcSel      (out_a[6]),
    .regWriteEn (out_a[5]),
    .flagWriteEn(out_a[4]),
    .memReadEn  (out_a[3]),
    .memWriteEn (out_a[2]),
    .mdStart    (out_a[1]),
    .mdFault    (out_a[0])
  );

  multicycle_controller #(
    .MD_TIMEOUT(4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .imemAck    (imemAck),
    .memReady   (memReady),
    .mdDone     (mdDone),
    .zeroFlag   (zeroFlag),
    .imemReq    (out_b[9]),
    .irWrite    (out_b[8]),
    .pcWrite    (out_b[7]),
    .pcSel      (out_b[6]),
    .regWriteEn (out_b[5]),
    .flagWriteEn(out_b[4]),
    .memReadEn  (out_b[3]),
    .memWriteEn (out_b[2]),
    .mdStart    (out_b[1]),
    .mdFault    (out_b[0])
  );

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (req ir pcw pcs rw fw mr mw mds flt)", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.tag, cur.sel ? out_b : out_a, cur.vec);
    end
  end

  // Inputs for this cycle are already applied; record expectation and advance one clock.
  task automatic cyc(input string tag, input bit sel, input logic [9:0] vec);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.vec = vec;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit sel);
    rst      = 1'b1;
    imemAck  = 1'b0;
    memReady = 1'b0;
    mdDone   = 1'b0;
    zeroFlag = 1'b0;
    cyc("reset", sel, E_NONE);
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] op, input bit sel, input logic [9:0] f);
    opcode  = op;
    imemAck = 1'b1;
    cyc("fetch", sel, E_IMEM | E_IR | E_PCW | f);
    imemAck = 1'b0;
    cyc("decode", sel, f);
  endtask

  initial begin
    logic [3:0] alu_ops[2];
    alu_ops[0] = 4'b0100;
    alu_ops[1] = 4'b1111;
    @(posedge clk);
    #1;

    // Reset state, then FETCH waits for imemAck
    do_reset(1'b0);
    cyc("fetch_wait", 1'b0, E_IMEM);
    cyc("fetch_wait2", 1'b0, E_IMEM);

    // ALU ops: flags in EXEC, register write in WB
    foreach (alu_ops[i]) begin
      fetch(alu_ops[i], 1'b0, E_NONE);
      cyc("alu_exec", 1'b0, E_FW);
      cyc("alu_wb", 1'b0, E_RW);
      cyc("alu_back", 1'b0, E_IMEM);
    end

    // Mul/div with result 7 cycles after start
    fetch(4'b0001, 1'b0, E_NONE);
    cyc("md_start", 1'b0, E_MDS);
    for (int i = 0; i < 6; i++) cyc("md_wait", 1'b0, E_NONE);
    mdDone = 1'b1;
    cyc("md_done", 1'b0, E_FW);
    mdDone = 1'b0;
    cyc("md_wb", 1'b0, E_RW);
    cyc("md_back", 1'b0, E_IMEM);

    // Load with memReady on the third MEM cycle
    fetch(4'b0101, 1'b0, E_NONE);
    cyc("ld_exec", 1'b0, E_NONE);
    cyc("ld_mem1", 1'b0, E_MR);
    cyc("ld_mem2", 1'b0, E_MR);
    memReady = 1'b1;
    cyc("ld_mem3", 1'b0, E_MR);
    memReady = 1'b0;
    cyc("ld_wb", 1'b0, E_RW);
    cyc("ld_back", 1'b0, E_IMEM);

    // Store with the same handshake, no writeback
    fetch(4'b0110, 1'b0, E_NONE);
    cyc("st_exec", 1'b0, E_NONE);
    cyc("st_mem1", 1'b0, E_MW);
    cyc("st_mem2", 1'b0, E_MW);
    memReady = 1'b1;
    cyc("st_mem3", 1'b0, E_MW);
    memReady = 1'b0;
    cyc("st_back", 1'b0, E_IMEM);

    // Branches and NOPs; stray handshakes in EXEC must be ignored
    fetch(4'b0111, 1'b0, E_NONE);
    cyc("b_exec", 1'b0, E_PCW | E_PCS);
    cyc("b_back", 1'b0, E_IMEM);
    zeroFlag = 1'b1;
    fetch(4'b1000, 1'b0, E_NONE);
    cyc("beq_taken", 1'b0, E_PCW | E_PCS);
    zeroFlag = 1'b0;
    fetch(4'b1000, 1'b0, E_NONE);
    cyc("beq_not", 1'b0, E_PCS);
    cyc("beq_back", 1'b0, E_IMEM);
    fetch(4'b1010, 1'b0, E_NONE);
    mdDone   = 1'b1;
    memReady = 1'b1;
    cyc("nop_exec", 1'b0, E_NONE);
    cyc("nop_back", 1'b0, E_IMEM);
    mdDone   = 1'b0;
    memReady = 1'b0;
    fetch(4'b0010, 1'b0, E_NONE);
    cyc("nop2_exec", 1'b0, E_NONE);
    cyc("nop2_back", 1'b0, E_IMEM);

    // Reset asserted mid-store drops strobes immediately; store is not retried
    fetch(4'b0110, 1'b0, E_NONE);
    cyc("rs_exec", 1'b0, E_NONE);
    cyc("rs_mem", 1'b0, E_MW);
    rst = 1'b1;
    cyc("rs_assert", 1'b0, E_NONE);
    rst = 1'b0;
    cyc("rs_fetch", 1'b0, E_IMEM);
    cyc("rs_noretry", 1'b0, E_IMEM);

    // Timeout (MD_TIMEOUT=4): abort after 4 wait cycles, sticky fault, no writeback
    do_reset(1'b1);
    fetch(4'b0011, 1'b1, E_NONE);
    cyc("to_start", 1'b1, E_MDS);
    for (int i = 0; i < 4; i++) cyc("to_wait", 1'b1, E_NONE);
    cyc("to_fault", 1'b1, E_IMEM | E_FLT);
    cyc("to_sticky", 1'b1, E_IMEM | E_FLT);

    // Result on the expiry cycle wins over the abort
    fetch(4'b0000, 1'b1, E_FLT);
    cyc("edge_start", 1'b1, E_MDS | E_FLT);
    for (int i = 0; i < 3; i++) cyc("edge_wait", 1'b1, E_FLT);
    mdDone = 1'b1;
    cyc("edge_done", 1'b1, E_FW | E_FLT);
    mdDone = 1'b0;
    cyc("edge_wb", 1'b1, E_RW | E_FLT);
    cyc("edge_back", 1'b1, E_IMEM | E_FLT);

    do_reset(1'b1);
    cyc("fault_clr", 1'b1, E_IMEM);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
